// File: rtl/pll_phase_sched.sv
//------------------------------------------------------------------------------
// Module   : pll_phase_sched
// Purpose  : Round-robin scheduler for the PLL dynamic phase-shift port (host A,
//            scan engine B). Optional step timeout enabled by PHASE_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pll_phase_sched #(
  parameter int SCAN_DIV = 16,
  parameter int TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] sel_a,
  input  logic [2:0] sel_b,
  input  logic       up_a,
  input  logic       up_b,
  input  logic [7:0] cnt_a,
  input  logic [7:0] cnt_b,
  output logic       ack_a,
  output logic       ack_b,
  input  logic       phasedone,
  output logic [2:0] phasecounterselect,
  output logic       phaseupdown,
  output logic       phasestep,
  output logic       scanclk,
  output logic       busy,
  output logic       done,
  output logic       owner,
  output logic [7:0] steps_done,
  output logic       timeout_err
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  if ((SCAN_DIV < 2) || (TIMEOUT < 1)) begin : g_param_check
    $error("pll_phase_sched: SCAN_DIV must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_ASSERT    = 3'd2,
    S_RELEASE   = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_NEXT      = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;
  logic [2:0]       r_sel;
  logic             r_up;
  logic [7:0]       r_cnt;
  logic [7:0]       r_steps;
  logic             r_scanclk;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_rises;
  logic             r_pd;
  logic             r_seen_low;
  logic             w_any_req;
  logic             w_win_b;
  logic             w_tick;
  logic             w_step_ok;
  logic             w_tmo;
  logic             w_scan_act;
  logic             w_scan_keep;

  assign w_any_req = req_a | req_b;
  // On a tie, the requester that did not own the last job wins.
  assign w_win_b   = (req_a && req_b) ? ~r_owner : req_b;
  assign w_tick    = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_step_ok = (r_state == S_WAIT_DONE) && r_seen_low && r_pd;
  assign w_scan_act  = (r_state == S_ASSERT) || (r_state == S_RELEASE) ||
                       (r_state == S_WAIT_DONE);
  assign w_scan_keep = w_scan_act && ((w_next == S_ASSERT) || (w_next == S_RELEASE) ||
                                      (w_next == S_WAIT_DONE));

`ifdef PHASE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  assign w_tmo       = (r_state == S_WAIT_DONE) && !w_step_ok &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT));
  assign timeout_err = r_tmo_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == S_WAIT_DONE) ? r_tmo_cnt + 1'b1 : '0;
      if ((r_state == S_IDLE) && w_any_req) begin
        r_tmo_err <= 1'b0;
      end else if (w_tmo) begin
        r_tmo_err <= 1'b1;
      end
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ack_a  = 1'b0;
    ack_b  = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_GRANT;
      end
      S_GRANT: begin
        ack_a = ~r_owner;
        ack_b = r_owner;
        if (r_cnt == 8'd0) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_ASSERT;
        end
      end
      S_ASSERT: begin
        // Leave on the falling edge that follows the second rising edge.
        if (w_tick && r_scanclk && (r_rises == 2'd2)) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_step_ok) begin
          w_next = S_NEXT;
        end else if (w_tmo) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_NEXT: begin
        if (r_steps == r_cnt) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_ASSERT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= 1'b1;
      r_sel      <= 3'b000;
      r_up       <= 1'b1;
      r_cnt      <= 8'd0;
      r_steps    <= 8'd0;
      r_scanclk  <= 1'b0;
      r_div      <= '0;
      r_rises    <= 2'd0;
      r_pd       <= 1'b1;
      r_seen_low <= 1'b0;
    end else begin
      r_pd <= phasedone;
      if ((r_state == S_IDLE) && w_any_req) begin
        r_owner <= w_win_b;
        r_sel   <= w_win_b ? sel_b : sel_a;
        r_up    <= w_win_b ? up_b  : up_a;
        r_cnt   <= w_win_b ? cnt_b : cnt_a;
        r_steps <= 8'd0;
      end else if (w_step_ok) begin
        r_steps <= r_steps + 8'd1;
      end
      if (w_scan_keep) begin
        if (w_tick) begin
          r_div     <= '0;
          r_scanclk <= ~r_scanclk;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end else begin
        r_div     <= '0;
        r_scanclk <= 1'b0;
      end
      if (r_state == S_ASSERT) begin
        if (w_tick && !r_scanclk) r_rises <= r_rises + 2'd1;
      end else begin
        r_rises <= 2'd0;
      end
      // The PLL may pull phasedone low while phasestep is still high.
      if (w_scan_act) begin
        if (!r_pd) r_seen_low <= 1'b1;
      end else begin
        r_seen_low <= 1'b0;
      end
    end
  end

  assign phasestep          = (r_state == S_ASSERT);
  assign busy               = (r_state != S_IDLE);
  assign scanclk            = r_scanclk;
  assign owner              = r_owner;
  assign steps_done         = r_steps;
  assign phasecounterselect = r_sel;
  assign phaseupdown        = r_up;

endmodule

`default_nettype wire

// File: tb/tb_pll_phase_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_pll_phase_sched
// Purpose  : Scoreboard bench for pll_phase_sched with a simple PLL phasedone
//            model. Timeout scenario active when PHASE_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pll_phase_sched;

  localparam int SCAN_DIV = 4;
  localparam int TIMEOUT  = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] sel_a = 3'd0, sel_b = 3'd0;
  logic       up_a = 1'b0, up_b = 1'b0;
  logic [7:0] cnt_a = 8'd0, cnt_b = 8'd0;
  logic       ack_a, ack_b, phasedone;
  logic [2:0] phasecounterselect;
  logic       phaseupdown, phasestep, scanclk, busy, done, owner, timeout_err;
  logic [7:0] steps_done;

  always #5 clk = ~clk;

  pll_phase_sched #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .sel_a(sel_a), .sel_b(sel_b),
    .up_a(up_a), .up_b(up_b), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .ack_a(ack_a), .ack_b(ack_b), .phasedone(phasedone),
    .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
    .phasestep(phasestep), .scanclk(scanclk), .busy(busy), .done(done),
    .owner(owner), .steps_done(steps_done), .timeout_err(timeout_err)
  );

  // PLL model: phasedone drops 6 cycles after phasestep rises, for 8 cycles.
  int   pll_t  = 100;
  logic ps_q   = 1'b0;
  bit   pll_en = 1'b1;
  always @(posedge clk) begin
    ps_q <= phasestep;
    if (phasestep && !ps_q && pll_en) pll_t <= 0;
    else if (pll_t < 100) pll_t <= pll_t + 1;
  end
  assign phasedone = !((pll_t >= 6) && (pll_t < 14));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit       owner;
    int       steps;
    bit [2:0] sel;
    bit       up;
    bit       tmo;
    int       pulses;
  } job_t;

  job_t q_job[$];
  job_t cur;
  bit   cur_valid = 1'b0;
  bit   chk_pend  = 1'b0;
  bit   hold_bad  = 1'b0;
  bit   ps_prev   = 1'b0;
  bit   sck_prev  = 1'b0;
  int   rises     = 0;
  int   pulses    = 0;

  // Monitor: binds each ack to the next queued job, checks it one cycle after done.
  always @(negedge clk) begin
    if (reset) begin
      cur_valid = 1'b0;
      chk_pend  = 1'b0;
      ps_prev   = 1'b0;
      sck_prev  = 1'b0;
      rises     = 0;
    end else begin
      if (chk_pend) begin
        chk("job_owner", int'(owner), int'(cur.owner));
        chk("job_steps", int'(steps_done), cur.steps);
        chk("job_tmo", int'(timeout_err), int'(cur.tmo));
        chk("job_pulses", pulses, cur.pulses);
        chk("job_sel", int'(phasecounterselect), int'(cur.sel));
        chk("job_up", int'(phaseupdown), int'(cur.up));
        chk("job_hold", int'(hold_bad), 0);
        chk_pend  = 1'b0;
        cur_valid = 1'b0;
      end
      if (ack_a || ack_b) begin
        if (q_job.size() == 0) begin
          chk("ack_unexpected", 1, 0);
        end else begin
          cur = q_job.pop_front();
          chk("ack_who", int'(ack_b), int'(cur.owner));
          cur_valid = 1'b1;
          hold_bad  = 1'b0;
          pulses    = 0;
        end
      end
      if (cur_valid && busy &&
          ((phasecounterselect != cur.sel) || (phaseupdown != cur.up)))
        hold_bad = 1'b1;
      if (phasestep && !ps_prev) rises = 0;
      if (phasestep && scanclk && !sck_prev) rises++;
      if (!phasestep && ps_prev) begin
        chk("step_scan_rises", rises, 2);
        pulses++;
      end
      if (done) begin
        if (!cur_valid) chk("done_unexpected", 1, 0);
        else chk_pend = 1'b1;
      end
      ps_prev  = phasestep;
      sck_prev = scanclk;
    end
  end

  task automatic issue(input bit b, input logic [2:0] s, input logic u, input logic [7:0] c,
                       input int exp_steps, input bit exp_tmo, input int exp_pulses);
    job_t j;
    j.owner = b; j.steps = exp_steps; j.sel = s; j.up = u; j.tmo = exp_tmo;
    j.pulses = exp_pulses;
    q_job.push_back(j);
    if (b) begin
      sel_b = s; up_b = u; cnt_b = c; req_b = 1'b1;
    end else begin
      sel_a = s; up_a = u; cnt_a = c; req_a = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit b, output int lat);
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (b ? ack_b : ack_a) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk(b ? "ack_b_timeout" : "ack_a_timeout", 0, 1);
    #1;
    if (b) req_b = 1'b0;
    else req_a = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && !cur_valid && !chk_pend) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  found;
    repeat (3) @(negedge clk);
    chk("rst_sel", int'(phasecounterselect), 0);
    chk("rst_up", int'(phaseupdown), 1);
    chk("rst_phasestep", int'(phasestep), 0);
    chk("rst_scanclk", int'(scanclk), 0);
    chk("rst_acks", int'({ack_a, ack_b}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_owner", int'(owner), 1);
    chk("rst_steps", int'(steps_done), 0);
    chk("rst_tmo", int'(timeout_err), 0);
    #1 reset = 1'b0;

    // Three-step job from A.
    issue(1'b0, 3'b011, 1'b1, 8'd3, 3, 1'b0, 3);
    wait_ack(1'b0, lat);
    chk("ack_latency", lat, 1);
    wait_idle();

    // Tie from reset: A first, then B; second tie goes to A again.
    do_reset();
    issue(1'b0, 3'b001, 1'b1, 8'd1, 1, 1'b0, 1);
    issue(1'b1, 3'b010, 1'b0, 8'd1, 1, 1'b0, 1);
    wait_ack(1'b0, lat);
    wait_ack(1'b1, lat);
    wait_idle();
    issue(1'b0, 3'b100, 1'b0, 8'd1, 1, 1'b0, 1);
    issue(1'b1, 3'b110, 1'b1, 8'd2, 2, 1'b0, 2);
    wait_ack(1'b0, lat);
    wait_ack(1'b1, lat);
    wait_idle();

    // Zero-step job: done in the grant cycle, no PLL activity.
    issue(1'b1, 3'b101, 1'b0, 8'd0, 0, 1'b0, 0);
    wait_ack(1'b1, lat);
    chk("zero_done", int'(done), 1);
    chk("zero_phasestep", int'(phasestep), 0);
    chk("zero_scanclk", int'(scanclk), 0);
    wait_idle();

    // Reset during the second step of a five-step job.
    issue(1'b0, 3'b101, 1'b1, 8'd5, 5, 1'b0, 5);
    wait_ack(1'b0, lat);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ((steps_done == 8'd1) && phasestep) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_step2", int'(found), 1);
    #1 reset = 1'b1;
    phasedone_mid: begin
      @(negedge clk);
      chk("midrst_phasestep", int'(phasestep), 0);
      chk("midrst_scanclk", int'(scanclk), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_up", int'(phaseupdown), 1);
      chk("midrst_done", int'(done), 0);
      chk("midrst_owner", int'(owner), 1);
    end
    #1 reset = 1'b0;
    issue(1'b0, 3'b010, 1'b1, 8'd1, 1, 1'b0, 1);
    wait_ack(1'b0, lat);
    chk("post_rst_ack_latency", lat, 1);
    wait_idle();

    // Down direction on all counters, held for the whole job.
    issue(1'b0, 3'b000, 1'b0, 8'd2, 2, 1'b0, 2);
    wait_ack(1'b0, lat);
    wait_idle();

`ifdef PHASE_TIMEOUT_EN
    pll_en = 1'b0;
    issue(1'b0, 3'b001, 1'b1, 8'd3, 0, 1'b1, 1);
    wait_ack(1'b0, lat);
    wait_idle();
    pll_en = 1'b1;
    issue(1'b1, 3'b001, 1'b1, 8'd1, 1, 1'b0, 1);
    wait_ack(1'b1, lat);
    chk("tmo_cleared_on_grant", int'(timeout_err), 0);
    wait_idle();
`endif

    chk("queue_empty", q_job.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
